// File: rtl/kyber_host_if.sv
// kyber_host_if: word-stream host initiator for the Kyber core (s_* operand stream in, m_* response stream out, core_* wide registers plus start/finish)
module kyber_host_if #(
  parameter int W       = 32,
  parameter int PK_BITS = 6400,
  parameter int SK_BITS = 6144,
  parameter int C_BITS  = 6144,
  parameter int M_BITS  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [W-1:0]       m_data,
  output logic               m_last,
  output logic               busy,
  output logic               core_start,
  output logic [1:0]         core_mode,
  output logic [M_BITS-1:0]  core_coin,
  output logic [M_BITS-1:0]  core_m,
  output logic [PK_BITS-1:0] core_pk,
  output logic [SK_BITS-1:0] core_sk,
  output logic [C_BITS-1:0]  core_c,
  input  logic               core_finish,
  input  logic [M_BITS-1:0]  core_m_out,
  input  logic [PK_BITS-1:0] core_pk_out,
  input  logic [SK_BITS-1:0] core_sk_out,
  input  logic [C_BITS-1:0]  core_c_out
);
  localparam logic [2:0] F_COIN = 3'd0, F_M = 3'd1, F_PK = 3'd2, F_SK = 3'd3, F_C = 3'd4;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SEND, ERR} state_t;
  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d, fcnt_q, fcnt_d, fnext;
  logic [7:0]         wcnt_q, wcnt_d, wnext;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d, busy_q, busy_d, start_q, start_d;
  logic [W-1:0]       m_data_q, m_data_d, rd_word;
  logic [M_BITS-1:0]  coin_q, coin_d, m_q, m_d;
  logic [PK_BITS-1:0] pk_q, pk_d;
  logic [SK_BITS-1:0] sk_q, sk_d;
  logic [C_BITS-1:0]  c_q, c_d;
  logic [2:0]         in_id, out_id, cur_id;
  logic               wr, rd, fld_end, lst_fld;
  function automatic logic [7:0] last_word(input logic [2:0] id);
    return id == F_PK ? 8'(PK_BITS / W - 1) : id == F_SK ? 8'(SK_BITS / W - 1) :
           id == F_C  ? 8'(C_BITS / W - 1)  : 8'(M_BITS / W - 1);
  endfunction
  // Field order per mode: load keygen coin / encaps m,pk / decaps c,sk,pk;
  // send keygen pk,sk / encaps c,m / decaps m.
  assign in_id   = mode_q == 2'd0 ? F_COIN : mode_q == 2'd1 ? (fcnt_q == 2'd0 ? F_M : F_PK) :
                   fcnt_q == 2'd0 ? F_C : fcnt_q == 2'd1 ? F_SK : F_PK;
  assign out_id  = mode_q == 2'd0 ? (fcnt_q == 2'd0 ? F_PK : F_SK) :
                   mode_q == 2'd1 ? (fcnt_q == 2'd0 ? F_C : F_M) : F_M;
  assign cur_id  = state_q == SEND ? out_id : in_id;
  assign fld_end = wcnt_q == last_word(cur_id);
  // Last load field index equals the mode number; decaps sends a single field.
  assign lst_fld = fcnt_q == (state_q == SEND ? (mode_q == 2'd2 ? 2'd0 : 2'd1) : mode_q);
  assign wnext   = fld_end ? 8'd0 : wcnt_q + 8'd1;
  assign fnext   = fld_end ? fcnt_q + 2'd1 : fcnt_q;
  assign rd_word = out_id == F_PK ? core_pk_out[int'(wcnt_q) * W +: W] :
                   out_id == F_SK ? core_sk_out[int'(wcnt_q) * W +: W] :
                   out_id == F_C  ? core_c_out[int'(wcnt_q) * W +: W]  : core_m_out[int'(wcnt_q) * W +: W];
  // Gated by rst_n so it reads 0 in reset yet is already 1 in the first cycle after release.
  assign s_ready = rst_n && (state_q == IDLE || state_q == LOAD);
  assign wr      = s_valid && s_ready;
  assign rd      = m_valid_q && m_ready;
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    coin_d    = coin_q;
    m_d       = m_q;
    pk_d      = pk_q;
    sk_d      = sk_q;
    c_d       = c_q;
    case (state_q)
      IDLE: if (wr) begin
        state_d   = s_data[1:0] == 2'b11 ? ERR : LOAD;
        mode_d    = s_data[1:0] == 2'b11 ? mode_q : s_data[1:0];
        fcnt_d    = '0;
        wcnt_d    = '0;
        m_valid_d = s_data[1:0] == 2'b11;
        m_last_d  = s_data[1:0] == 2'b11;
        m_data_d  = s_data[1:0] == 2'b11 ? W'(9'h103) : '0;
      end
      LOAD: if (wr) begin
        if (in_id == F_COIN) coin_d[int'(wcnt_q) * W +: W] = s_data;
        if (in_id == F_M) m_d[int'(wcnt_q) * W +: W] = s_data;
        if (in_id == F_PK) pk_d[int'(wcnt_q) * W +: W] = s_data;
        if (in_id == F_SK) sk_d[int'(wcnt_q) * W +: W] = s_data;
        if (in_id == F_C) c_d[int'(wcnt_q) * W +: W] = s_data;
        wcnt_d  = wnext;
        fcnt_d  = fnext;
        state_d = fld_end && lst_fld ? START : LOAD;
      end
      START: state_d = WAIT;
      WAIT: if (core_finish) begin
        state_d   = SEND;
        m_valid_d = 1'b1;
        m_last_d  = 1'b0;
        m_data_d  = W'(mode_q);
        fcnt_d    = '0;
        wcnt_d    = '0;
      end
      SEND: if (rd) begin
        state_d   = m_last_q ? IDLE : SEND;
        m_valid_d = !m_last_q;
        m_data_d  = m_last_q ? '0 : rd_word;
        m_last_d  = !m_last_q && fld_end && lst_fld;
        wcnt_d    = m_last_q ? wcnt_q : wnext;
        fcnt_d    = m_last_q ? fcnt_q : fnext;
      end
      ERR: if (rd) begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_data_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    start_d = state_d == START;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      coin_q    <= '0;
      m_q       <= '0;
      pk_q      <= '0;
      sk_q      <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      coin_q    <= coin_d;
      m_q       <= m_d;
      pk_q      <= pk_d;
      sk_q      <= sk_d;
      c_q       <= c_d;
    end
  end
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign core_start = start_q;
  assign core_mode  = mode_q;
  assign core_coin  = coin_q;
  assign core_m     = m_q;
  assign core_pk    = pk_q;
  assign core_sk    = sk_q;
  assign core_c     = c_q;
endmodule

// File: tb/tb_kyber_host_if.sv
// tb_kyber_host_if: randomized scoreboard bench for kyber_host_if with a stub Kyber core
module tb_kyber_host_if;
  localparam int W = 32;
  typedef struct {logic [31:0] d; logic l;} ow_t;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, m_valid, m_ready = 1, m_last, busy, core_start, core_finish = 0;
  logic [31:0] s_data = 0, m_data;
  logic [1:0] core_mode;
  logic [255:0] core_coin, core_m, core_m_out = '0;
  logic [6399:0] core_pk, core_pk_out = '0;
  logic [6143:0] core_sk, core_c, core_sk_out = '0, core_c_out = '0;
  int n_chk = 0, n_fail = 0, starts = 0, popped = 0, rdy_mode = 0;
  bit gaps = 0;
  logic [1:0] exp_mode = 0;
  ow_t exp_q[$];
  logic [31:0] coin_m[8], m_m[8], pk_m[200], sk_m[192], c_m[192];

  always #5 clk = ~clk;

  kyber_host_if dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .core_start(core_start), .core_mode(core_mode), .core_coin(core_coin), .core_m(core_m),
    .core_pk(core_pk), .core_sk(core_sk), .core_c(core_c), .core_finish(core_finish),
    .core_m_out(core_m_out), .core_pk_out(core_pk_out), .core_sk_out(core_sk_out), .core_c_out(core_c_out)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", nm);
  endtask

  function automatic void zero_model();
    for (int k = 0; k < 8; k++) begin coin_m[k] = 0; m_m[k] = 0; end
    for (int k = 0; k < 200; k++) pk_m[k] = 0;
    for (int k = 0; k < 192; k++) begin sk_m[k] = 0; c_m[k] = 0; end
  endfunction

  // Stub core behaviour: pk_out[k]=coin[k%8]+k, sk_out[k]=~coin[k%8],
  // c_out[k]=m[k%8], m_out = top 8 words of c_out.
  function automatic void push_expected(input logic [1:0] md);
    if (md == 2'd3) begin
      exp_q.push_back('{32'h103, 1'b1});
      return;
    end
    exp_q.push_back('{{30'd0, md}, 1'b0});
    if (md == 2'd0) begin
      for (int k = 0; k < 200; k++) exp_q.push_back('{32'(coin_m[k % 8] + k), 1'b0});
      for (int k = 0; k < 192; k++) exp_q.push_back('{~coin_m[k % 8], k == 191});
    end else if (md == 2'd1) begin
      for (int k = 0; k < 192; k++) exp_q.push_back('{m_m[k % 8], 1'b0});
      for (int k = 0; k < 8; k++) exp_q.push_back('{m_m[(184 + k) % 8], k == 7});
    end else
      for (int k = 0; k < 8; k++) exp_q.push_back('{m_m[(184 + k) % 8], k == 7});
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_ready : 1'($urandom_range(0, 1));
  end

  // Monitor: compares accepted words and checks that stalled words do not change.
  initial begin
    bit stall = 0;
    logic [31:0] sd;
    logic sl;
    ow_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 0;
      else begin
        if (stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, sd);
          chk("stall_last", m_last, sl);
        end
        stall = m_valid && !m_ready;
        sd = m_data;
        sl = m_last;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) bad("extra_output_word");
          else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e.d);
            chk("m_last", m_last, e.l);
          end
          popped++;
        end
      end
    end
  end

  // Stub core: checks operand registers at start, produces results, pulses finish.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        starts++;
        chk("core_mode", core_mode, exp_mode);
        e = 0;
        for (int k = 0; k < 8; k++) e += int'(core_coin[k*W +: W] !== coin_m[k]) + int'(core_m[k*W +: W] !== m_m[k]);
        chk("core_coin_m_regs", e, 0);
        e = 0;
        for (int k = 0; k < 200; k++) e += int'(core_pk[k*W +: W] !== pk_m[k]);
        chk("core_pk_reg", e, 0);
        e = 0;
        for (int k = 0; k < 192; k++) e += int'(core_sk[k*W +: W] !== sk_m[k]) + int'(core_c[k*W +: W] !== c_m[k]);
        chk("core_sk_c_regs", e, 0);
        for (int k = 0; k < 200; k++) core_pk_out[k*W +: W] = core_coin[(k % 8)*W +: W] + 32'(k);
        for (int k = 0; k < 192; k++) core_sk_out[k*W +: W] = ~core_coin[(k % 8)*W +: W];
        for (int k = 0; k < 192; k++) core_c_out[k*W +: W] = core_m[(k % 8)*W +: W];
        core_m_out = core_c_out[6143 -: 256];
        repeat ($urandom_range(0, 5)) @(posedge clk);
        @(posedge clk);
        #1 core_finish = 1;
        @(posedge clk);
        #1 core_finish = 0;
        chk("finish_to_valid", m_valid, 1);
        @(negedge clk);
        chk("start_one_cycle", core_start, 0);
      end
    end
  end

  task automatic put(input logic [31:0] d);
    int t = 0;
    bit acc = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_valid = 1;
    s_data = d;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    s_valid = 0;
    if (!acc) bad("s_ready_wait");
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_outputs", {s_ready, m_valid, m_last, busy, core_start, core_mode, m_data}, 0);
    chk("rst_core_regs", {|core_coin, |core_m, |core_pk, |core_sk, |core_c}, 0);
    exp_q.delete();
    zero_model();
    s_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("s_ready_after_rst", s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] cmd, input bit dir, input int abort_load, input int abort_send);
    logic [31:0] wq[$];
    logic [1:0] md;
    int st0, p0, t;
    md = cmd[1:0];
    st0 = starts;
    wq.push_back(cmd);
    if (md == 2'd0)
      for (int k = 0; k < 8; k++) begin coin_m[k] = dir ? 32'h11111111 * k : $urandom; wq.push_back(coin_m[k]); end
    if (md == 2'd1) begin
      for (int k = 0; k < 8; k++) begin m_m[k] = dir ? 32'hA5A5A5A5 : $urandom; wq.push_back(m_m[k]); end
      for (int k = 0; k < 200; k++) begin pk_m[k] = dir ? 32'(k) : $urandom; wq.push_back(pk_m[k]); end
    end
    if (md == 2'd2) begin
      for (int k = 0; k < 192; k++) begin c_m[k] = $urandom; wq.push_back(c_m[k]); end
      for (int k = 0; k < 192; k++) begin sk_m[k] = $urandom; wq.push_back(sk_m[k]); end
      for (int k = 0; k < 200; k++) begin pk_m[k] = $urandom; wq.push_back(pk_m[k]); end
    end
    if (md != 2'd3) exp_mode = md;
    push_expected(md);
    for (int i = 0; i < wq.size(); i++) begin
      if (abort_load >= 0 && i == abort_load + 1) begin
        do_reset();
        return;
      end
      put(wq[i]);
    end
    if (md != 2'd3) begin
      chk("start_latency", core_start, 1);
      s_valid = 1;
      s_data = $urandom;
      repeat (2) begin @(posedge clk); #1; end
      s_valid = 0;
    end
    if (abort_send >= 0) begin
      p0 = popped;
      t = 0;
      while (popped - p0 < abort_send && t < 5000) begin @(posedge clk); #1; t++; end
      if (t >= 5000) bad("send_progress");
      do_reset();
      return;
    end
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin @(posedge clk); #1; t++; end
    if (t >= 5000) bad("response_done");
    chk("busy_after_resp", busy, 0);
    chk("start_count", starts - st0, md == 2'd3 ? 0 : 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    zero_model();
    #3;
    chk("rst_outputs0", {s_ready, m_valid, m_last, busy, core_start, core_mode, m_data}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("s_ready_after_rst0", s_ready, 1);
    @(posedge clk);
    #1;
    run_cmd(32'h0, 1, -1, -1);
    run_cmd(32'h1, 1, -1, -1);
    chk("core_pk_lsw", core_pk[31:0], 0);
    chk("core_pk_msw", core_pk[6399:6368], 199);
    run_cmd(32'hFFFFFFFE, 0, -1, -1);
    run_cmd(32'h3, 0, -1, -1);
    core_finish = 1;
    @(posedge clk);
    #1 core_finish = 0;
    @(negedge clk);
    chk("finish_in_idle_busy", busy, 0);
    chk("finish_in_idle_valid", m_valid, 0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    gaps = 1;
    for (int i = 0; i < 4; i++) run_cmd({30'($urandom), 2'(i)}, 0, -1, -1);
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) run_cmd($urandom, 0, -1, -1);
    rdy_mode = 0;
    gaps = 0;
    run_cmd(32'h1, 0, 108, -1);
    run_cmd(32'h0, 1, -1, -1);
    rdy_mode = 2;
    run_cmd(32'h0, 0, -1, 50);
    rdy_mode = 0;
    run_cmd(32'h0, 1, -1, -1);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
